// File: rtl/adder_entry_ctrl.sv
// Operand-entry sequencer: debounced "enter" button steps an FSM that captures A, then B,
// from the switch bus, performs one registered add with carry-out and drives display enables.
module adder_entry_ctrl #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             enter_btn,
   input  logic             clear,
   output logic [WIDTH-1:0] a_q,
   output logic [WIDTH-1:0] b_q,
   output logic [WIDTH-1:0] sum_q,
   output logic             cout_q,
   output logic             result_valid,
   output logic [1:0]       state_o,
   output logic [2:0]       disp_en
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HAVE_A = 2'd1,
      ADD    = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t         state, state_d;
   logic           s1, s2, deb, deb_prev;
   logic [CW-1:0]  cnt;
   logic           press;
   logic [WIDTH-1:0] a_d, b_d, sum_d;
   logic           cout_d, rv_d;
   logic [WIDTH:0] add_w;

   // Two-flop synchronizer, then a level debouncer that only counts while s2 disagrees with deb.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         deb      <= 1'b0;
         deb_prev <= 1'b0;
         cnt      <= '0;
      end else begin
         s1       <= enter_btn;
         s2       <= s1;
         deb_prev <= deb;
         if (s2 == deb) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign press = deb & ~deb_prev;
   assign add_w = {1'b0, a_q} + {1'b0, b_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         sum_q        <= '0;
         cout_q       <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         state        <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         sum_q        <= sum_d;
         cout_q       <= cout_d;
         result_valid <= rv_d;
      end
   end

   // Clear wins over any press and over the ADD step.
   always_comb begin
      state_d = state;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      rv_d    = 1'b0;
      if (clear) begin
         state_d = IDLE;
         a_d     = '0;
         b_d     = '0;
         sum_d   = '0;
         cout_d  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (press) begin
                  a_d     = din;
                  state_d = HAVE_A;
               end
            end
            HAVE_A: begin
               if (press) begin
                  b_d     = din;
                  state_d = ADD;
               end
            end
            ADD: begin
               sum_d   = add_w[WIDTH-1:0];
               cout_d  = add_w[WIDTH];
               rv_d    = 1'b1;
               state_d = DONE;
            end
            DONE: begin
               if (press) begin
                  a_d     = din;
                  b_d     = '0;
                  state_d = HAVE_A;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      disp_en = 3'b000;
      case (state)
         IDLE:    disp_en = 3'b000;
         HAVE_A:  disp_en = 3'b001;
         ADD:     disp_en = 3'b011;
         DONE:    disp_en = 3'b111;
         default: disp_en = 3'b000;
      endcase
   end

   assign state_o = state;

endmodule

// File: tb/tb_adder_entry_ctrl.sv
// Bench for adder_entry_ctrl: directed presses, expected results and state transitions queued
// by the stimulus and popped by negedge monitors.
module tb_adder_entry_ctrl;
  localparam int W  = 8;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic         enter_btn = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] a_q, b_q, sum_q;
  logic         cout_q, result_valid;
  logic [1:0]   state_o;
  logic [2:0]   disp_en;

  adder_entry_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .din(din), .enter_btn(enter_btn), .clear(clear),
    .a_q(a_q), .b_q(b_q), .sum_q(sum_q), .cout_q(cout_q),
    .result_valid(result_valid), .state_o(state_o), .disp_en(disp_en)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [W:0]       exp_q[$];     // {cout, sum}
  logic [2*W+4:0]   exp_st_q[$];  // {state, disp_en, a, b}
  int               n_cmp = 0;
  int               n_err = 0;
  logic [1:0]       prev_state = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W+4:0] st(input logic [1:0] s, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2:0] d;
    case (s)
      2'd0: d = 3'b000;
      2'd1: d = 3'b001;
      2'd2: d = 3'b011;
      default: d = 3'b111;
    endcase
    return {s, d, a, b};
  endfunction

  // monitor: result pulses and every state change
  always @(negedge clk) begin
    if (!rst) begin
      if (result_valid) begin
        if (exp_q.size() == 0) check("unexpected_result_valid", 32'(1), 32'(0));
        else check("result_cout_sum", 32'({cout_q, sum_q}), 32'(exp_q.pop_front()));
      end
      if (state_o != prev_state) begin
        if (exp_st_q.size() == 0) check("unexpected_state_change", 32'(state_o), 32'(prev_state));
        else check("state_disp_a_b", 32'({state_o, disp_en, a_q, b_q}), 32'(exp_st_q.pop_front()));
      end
      prev_state <= state_o;
    end
  end

  // driver: press with din=early until after edge 5, then v; capture expected exactly at edge 7
  task automatic press(input logic [W-1:0] v, input logic [W-1:0] early,
                       input logic [1:0] before_s, input logic [1:0] after_s);
    @(negedge clk);
    enter_btn = 1'b1;
    din = early;
    repeat (5) @(posedge clk);
    #1 din = v;
    @(posedge clk);
    #1 check("state_at_edge6", 32'(state_o), 32'(before_s));
    @(posedge clk);
    #1 check("state_at_edge7", 32'(state_o), 32'(after_s));
    enter_btn = 1'b0;
    repeat (DB + 4) @(posedge clk);
  endtask

  task automatic add_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] from_s,
                          input logic [W:0] exp_res);
    exp_st_q.push_back(st(2'd1, a, '0));
    press(a, ~a, from_s, 2'd1);
    exp_st_q.push_back(st(2'd2, a, b));
    exp_st_q.push_back(st(2'd3, a, b));
    exp_q.push_back(exp_res);
    press(b, ~b, 2'd1, 2'd2);
  endtask

  initial begin
    #1 check("reset_async_state", 32'(state_o), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", 32'(a_q), 32'(0));
    check("reset_b", 32'(b_q), 32'(0));
    check("reset_sum_cout", 32'({cout_q, sum_q}), 32'(0));
    check("reset_rv_disp", 32'({result_valid, disp_en}), 32'(0));
    @(negedge clk) rst = 1'b0;

    // basic add
    add_pair(8'h12, 8'h34, 2'd0, 9'h046);

    // restart from DONE keeps the old sum
    exp_st_q.push_back(st(2'd1, 8'h05, 8'h00));
    press(8'h05, 8'hAA, 2'd3, 2'd1);
    check("restart_sum_kept", 32'({cout_q, sum_q}), 32'(9'h046));
    check("restart_b_zero", 32'(b_q), 32'(0));

    // clear coincident with a press in HAVE_A
    @(negedge clk);
    enter_btn = 1'b1;
    din = 8'h77;
    repeat (6) @(posedge clk);
    #1 clear = 1'b1;
    exp_st_q.push_back(st(2'd0, 8'h00, 8'h00));
    @(posedge clk);
    #1 clear = 1'b0;
    check("clear_state", 32'(state_o), 32'(0));
    check("clear_a_b", 32'({a_q, b_q}), 32'(0));
    check("clear_sum_cout_rv", 32'({cout_q, sum_q, result_valid}), 32'(0));
    enter_btn = 1'b0;
    repeat (DB + 4) @(posedge clk);
    #1 check("clear_no_capture", 32'(state_o), 32'(0));

    // carry cases
    add_pair(8'hFF, 8'h01, 2'd0, 9'h100);
    add_pair(8'h80, 8'h80, 2'd3, 9'h100);
    add_pair(8'h7F, 8'h01, 2'd3, 9'h080);

    // back to IDLE, then short glitches must be rejected
    @(negedge clk) clear = 1'b1;
    exp_st_q.push_back(st(2'd0, 8'h00, 8'h00));
    @(negedge clk) clear = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      enter_btn = 1'b1;
      din = 8'h5A;
      repeat (k) @(negedge clk);
      enter_btn = 1'b0;
      repeat (2 * DB + 4) @(posedge clk);
      #1 check($sformatf("glitch_%0d_state", k), 32'({state_o, a_q}), 32'(0));
    end

    // clean press, din changes before edge 7
    exp_st_q.push_back(st(2'd1, 8'h3C, 8'h00));
    press(8'h3C, 8'hC3, 2'd0, 2'd1);

    // async reset while held with cnt=2, then the held button is a fresh press
    @(negedge clk);
    enter_btn = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    exp_st_q.push_back(st(2'd0, 8'h00, 8'h00));
    #1 check("async_rst_outputs", 32'({state_o, disp_en, a_q, b_q}), 32'(0));
    #1 rst = 1'b0;
    exp_st_q.push_back(st(2'd1, 8'h21, 8'h00));
    press(8'h21, 8'h21, 2'd0, 2'd1);

    repeat (4) @(posedge clk);
    #1;
    check("result_queue_drained", 32'(exp_q.size()), 32'(0));
    check("state_queue_drained", 32'(exp_st_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/adder_entry_ctrl.md
# adder_entry_ctrl

Operand-entry sequencer for the 8-bit registered adder datapath driven from board switches and a push button. It debounces a raw "enter" button and walks a 4-state FSM that captures operand A, then operand B, from the same switch bus. It then performs one registered add with carry-out and presents A, B, the sum and the carry, with per-field display enables, to the downstream hex_to_7_seg decoders and LED.

## Interface
- WIDTH, 8, operand/sum width
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a button level change (≥2; board builds override with a large value)

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- din  in  WIDTH  operand value (switches), sampled only on accepted presses
- enter_btn  in  1  raw button, active-high pressed, asynchronous to clk
- clear  in  1  synchronous clear, active-high, single-cycle or level
- a_q  out  WIDTH  captured operand A
- b_q  out  WIDTH  captured operand B
- sum_q  out  WIDTH  registered sum, a_q+b_q mod 2^WIDTH
- cout_q  out  1  registered carry-out of the add
- result_valid  out  1  one-cycle pulse when sum_q/cout_q update
- state_o  out  2  current FSM state encoding
- disp_en  out  3  {sum, b, a} display enables

## Operation
- Reset (rst=1, asynchronous): all outputs and internal registers are 0. This covers the synchronizer, the debounced level, the debounce counter, and the state (IDLE).
- Synchronizer: 2 flops on enter_btn, output s2.
- Debounce: registered level deb, counter cnt.
  - s2==deb → cnt<=0.
  - s2!=deb and cnt==DEBOUNCE_CYCLES-1 → deb<=s2, cnt<=0.
  - Otherwise cnt<=cnt+1.
- press = deb & ~deb_prev: one-cycle pulse on each accepted rising level; release produces no press.
- FSM states (state_o): IDLE=0, HAVE_A=1, ADD=2, DONE=3.
  - IDLE: press → a_q<=din, go HAVE_A.
  - HAVE_A: press → b_q<=din, go ADD.
  - ADD: unconditional, one cycle. {cout_q,sum_q}<=a_q+b_q, computed at WIDTH+1 bits. result_valid<=1 for exactly the next cycle. Go DONE. press in ADD is ignored.
  - DONE: hold all values. press → a_q<=din, b_q<=0, go HAVE_A. sum_q/cout_q are retained until the next ADD.
- disp_en: IDLE 000, HAVE_A 001, ADD 011, DONE 111.
- clear=1: next edge forces IDLE and zeroes a_q, b_q, sum_q, cout_q, result_valid. It overrides any simultaneous press and the ADD transition. Debounce state is unaffected.
- din is never registered except on a press. Switch changes between presses have no effect.

## Timing
- Edge 1 is the first clk edge sampling enter_btn=1, held stable. s2=1 after edge 2. deb=1 after edge 2+DEBOUNCE_CYCLES. press is high in the following cycle. The capture register updates at edge 3+DEBOUNCE_CYCLES (edge 7 at default).
- A level on s2 held for fewer than DEBOUNCE_CYCLES cycles is rejected, because cnt resets on any return to deb.
- Release is accepted after the same latency. A new press requires a full release-accept first, so at most one press occurs per 2·DEBOUNCE_CYCLES cycles.
- ADD→DONE takes 1 cycle. sum_q, cout_q and result_valid become visible together, one edge after ADD is entered.
- Reset mid-operation or mid-debounce: immediate return to all-zero state. A button still held after rst deasserts is accepted as a new press after the normal latency.
- Width rule: sum_q = (a_q+b_q) mod 2^WIDTH; cout_q = bit WIDTH of the (WIDTH+1)-bit sum.

## Test plan
- Basic add: rst pulse. Press with din=0x12, then press with din=0x34. Required: a_q=0x12, b_q=0x34, sum_q=0x46, cout_q=0, one result_valid pulse, state_o 0→1→2→3, disp_en 000→001→011→111.
- Carry: A=0xFF, B=0x01. Required: sum_q=0x00, cout_q=1. Then A=0x80, B=0x80 → sum_q=0x00, cout_q=1. Then A=0x7F, B=0x01 → sum_q=0x80, cout_q=0.
- Debounce: with DEBOUNCE_CYCLES=4, glitches on enter_btn of 1, 2 and 3 cycles. Required: no press, state stays IDLE. A clean press is captured exactly at edge 7; din changing before edge 7 is captured at its edge-7 value.
- DONE restart: after 0x12+0x34, press with din=0x05. Required: a_q=0x05, b_q=0, state HAVE_A, sum_q still 0x46 until the next ADD.
- Clear priority: assert clear in the same cycle as a press in HAVE_A. Required: state IDLE, all outputs 0, no capture.
- Async reset mid-debounce: raise rst for a partial clk period while cnt=2 and the button is held. Required: outputs 0 immediately. After rst drops with the button still held, a press occurs after 3+DEBOUNCE_CYCLES edges.
